framebuffer_swap_ctrl: RTL and testbench

//   Double-buffer controller for the 160x120x12 framebuffer pair behind the Display read port.
//   - Owns front/back selection: Display reads the front buffer (front_sel); the renderer writes the back buffer.
//   - Sequences a tear-free swap at end of frame, then optionally clears the new back buffer to a fixed colour.
//   - Arbitrates the shared back-buffer write port between the renderer and the internal clear engine.

---
 rtl/framebuffer_swap_ctrl.sv | 108 ++++++++++
 tb/tb_framebuffer_swap_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_swap_ctrl.sv
// Double-buffer controller for the display framebuffer pair: owns front/back selection,
// sequences a tear-free swap at end of frame, optionally clears the new back buffer.
module framebuffer_swap_ctrl #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12,
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic              clk_pixel,
  input  logic              rstn_pixel,
  input  logic              frame_end,
  input  logic              swap_req,
  input  logic              clear_en,
  input  logic [DATA_W-1:0] clear_color,
  output logic              busy,
  output logic              swap_ack,
  output logic              front_sel,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              fb_wr_en,
  output logic              fb_wr_sel,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [DATA_W-1:0] fb_wr_data
);

  localparam int                PIXELS    = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_FE = 2'd1;
  localparam logic [1:0] CLEAR   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]        state;
  logic              clear_en_q;
  logic [DATA_W-1:0] clear_color_q;
  logic [ADDR_W-1:0] clr_cnt;
  logic              wr_acc;
  logic              clr_wr;

  assign busy     = (state != IDLE);
  assign wr_ready = (state == IDLE) || (state == WAIT_FE);
  assign wr_acc   = wr_en && wr_ready;
  assign clr_wr   = (state == CLEAR);

  always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
    if (!rstn_pixel) begin
      state      <= IDLE;
      front_sel  <= 1'b0;
      swap_ack   <= 1'b0;
      clear_en_q <= 1'b0;
      clr_cnt    <= '0;
    end else begin
      swap_ack <= (state == DONE);
      case (state)
        IDLE: begin
          if (swap_req) begin
            clear_en_q <= clear_en;
            state      <= WAIT_FE;
          end
        end
        WAIT_FE: begin
          if (frame_end) begin
            front_sel <= ~front_sel;
            state     <= clear_en_q ? CLEAR : DONE;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            clr_cnt <= '0;
            state   <= DONE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if ((state == IDLE) && swap_req) clear_color_q <= clear_color;
  end

  // Write stage: renderer and clear engine share one registered path; back = ~front_sel
  // at issue, so a write accepted on the frame_end cycle still lands in the old back buffer.
  always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
    if (!rstn_pixel) begin
      fb_wr_en   <= 1'b0;
      fb_wr_sel  <= 1'b0;
      fb_wr_addr <= '0;
      fb_wr_data <= '0;
    end else begin
      fb_wr_en  <= wr_acc || clr_wr;
      fb_wr_sel <= ~front_sel;
      if (clr_wr) begin
        fb_wr_addr <= clr_cnt;
        fb_wr_data <= clear_color_q;
      end else if (wr_acc) begin
        fb_wr_addr <= wr_addr;
        fb_wr_data <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_swap_ctrl.sv
// Directed bench for framebuffer_swap_ctrl: swap, clear, write arbitration, reset abort.
module tb_framebuffer_swap_ctrl;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 12;
  localparam int PIXELS = 19200;

  logic              clk_pixel = 1'b0;
  logic              rstn_pixel = 1'b0;
  logic              frame_end = 1'b0;
  logic              swap_req = 1'b0;
  logic              clear_en = 1'b0;
  logic [DATA_W-1:0] clear_color = '0;
  logic              busy;
  logic              swap_ack;
  logic              front_sel;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              fb_wr_en;
  logic              fb_wr_sel;
  logic [ADDR_W-1:0] fb_wr_addr;
  logic [DATA_W-1:0] fb_wr_data;

  int n_assert = 0;
  int n_fail   = 0;

  framebuffer_swap_ctrl dut (
    .clk_pixel  (clk_pixel),
    .rstn_pixel (rstn_pixel),
    .frame_end  (frame_end),
    .swap_req   (swap_req),
    .clear_en   (clear_en),
    .clear_color(clear_color),
    .busy       (busy),
    .swap_ack   (swap_ack),
    .front_sel  (front_sel),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .fb_wr_en   (fb_wr_en),
    .fb_wr_sel  (fb_wr_sel),
    .fb_wr_addr (fb_wr_addr),
    .fb_wr_data (fb_wr_data)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int bad;
    int first_bad;
    int acks;
    int k;
    logic got_ack;

    // Reset state
    tick(); tick();
    chk("rst_front_sel", front_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_swap_ack", swap_ack, 0);
    chk("rst_fb_wr_en", fb_wr_en, 0);
    chk("rst_fb_wr_addr", fb_wr_addr, 0);
    chk("rst_wr_ready", wr_ready, 1);
    rstn_pixel = 1'b1;
    tick();

    // Test 1: swap without clear
    swap_req = 1'b1; clear_en = 1'b0;
    tick();
    swap_req = 1'b0;
    chk("t1_busy_after_req", busy, 1);
    chk("t1_front_before", front_sel, 0);
    for (int i = 0; i < 9; i++) tick();
    chk("t1_front_still0", front_sel, 0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("t1_front_toggled", front_sel, 1);
    chk("t1_ack_not_yet", swap_ack, 0);
    chk("t1_busy_in_done", busy, 1);
    tick();
    chk("t1_ack_pulse", swap_ack, 1);
    chk("t1_busy_low", busy, 0);
    tick();
    chk("t1_ack_single", swap_ack, 0);

    // Test 2: swap with clear from a fresh reset
    rstn_pixel = 1'b0;
    #1;
    chk("t2_reset_front", front_sel, 0);
    rstn_pixel = 1'b1;
    tick();
    swap_req = 1'b1; clear_en = 1'b1; clear_color = 12'hF00;
    tick();
    swap_req = 1'b0; clear_en = 1'b0; clear_color = 12'h000;
    tick(); tick();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("t2_front_toggled", front_sel, 1);
    chk("t2_wr_ready_clear", wr_ready, 0);
    chk("t2_no_write_yet", fb_wr_en, 0);
    bad = 0; first_bad = -1;
    for (int i = 0; i < PIXELS; i++) begin
      tick();
      if (!(fb_wr_en === 1'b1 && fb_wr_sel === 1'b0 && fb_wr_addr === ADDR_W'(i) &&
            fb_wr_data === 12'hF00 && swap_ack === 1'b0)) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
    end
    chk("t2_clear_run_bad_cycles", bad, 0);
    tick();
    chk("t2_ack_after_clear", swap_ack, 1);
    chk("t2_wr_en_off", fb_wr_en, 0);
    chk("t2_busy_low", busy, 0);
    tick();
    chk("t2_ack_single", swap_ack, 0);

    // Test 3: renderer write in IDLE with front_sel=1
    wr_en = 1'b1; wr_addr = 15'd5; wr_data = 12'h0A0;
    chk("t3_wr_ready_idle", wr_ready, 1);
    tick();
    wr_en = 1'b0;
    chk("t3_fb_wr_en", fb_wr_en, 1);
    chk("t3_fb_wr_sel", fb_wr_sel, 0);
    chk("t3_fb_wr_addr", fb_wr_addr, 5);
    chk("t3_fb_wr_data", fb_wr_data, 12'h0A0);
    tick();
    chk("t3_fb_wr_en_off", fb_wr_en, 0);

    // Test 3b: renderer held off during a clear into buffer 1
    swap_req = 1'b1; clear_en = 1'b1; clear_color = 12'h00F;
    tick();
    swap_req = 1'b0; clear_en = 1'b0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("t3b_front", front_sel, 0);
    wr_en = 1'b1; wr_addr = 15'd7; wr_data = 12'hABC;
    tick();
    chk("t3b_wr_ready", wr_ready, 0);
    chk("t3b_first_en", fb_wr_en, 1);
    chk("t3b_first_sel", fb_wr_sel, 1);
    chk("t3b_first_addr", fb_wr_addr, 0);
    chk("t3b_first_data", fb_wr_data, 12'h00F);
    tick();
    chk("t3b_second_addr", fb_wr_addr, 1);
    bad = 0; got_ack = 1'b0;
    for (int i = 0; i < PIXELS + 10 && !got_ack; i++) begin
      tick();
      if (swap_ack) begin
        got_ack = 1'b1;
        wr_en = 1'b0;
      end else if (fb_wr_en && (fb_wr_data !== 12'h00F || wr_ready)) begin
        bad++;
      end
    end
    chk("t3b_ack_seen", got_ack, 1);
    chk("t3b_renderer_leaks", bad, 0);
    tick();

    // Test 5: reset during clear at address 1000
    swap_req = 1'b1; clear_en = 1'b1; clear_color = 12'h123;
    tick();
    swap_req = 1'b0; clear_en = 1'b0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("t5_front_swapped", front_sel, 1);
    k = 0;
    while (k < 2000 && !(fb_wr_en && fb_wr_addr == 15'd1000)) begin
      tick();
      k++;
    end
    chk("t5_reached_1000", fb_wr_addr, 1000);
    rstn_pixel = 1'b0;
    #1;
    chk("t5_fb_wr_en", fb_wr_en, 0);
    chk("t5_front_sel", front_sel, 0);
    chk("t5_busy", busy, 0);
    chk("t5_wr_ready", wr_ready, 1);
    tick();
    rstn_pixel = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (swap_ack) acks++;
    end
    chk("t5_no_ack_after_reset", acks, 0);
    chk("t5_still_idle", busy, 0);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("t5_new_swap_front", front_sel, 1);
    tick();
    chk("t5_new_swap_ack", swap_ack, 1);
    tick();

    // Test 4: coincident swap_req/frame_end, second request while busy
    swap_req = 1'b1; frame_end = 1'b1;
    tick();
    swap_req = 1'b0; frame_end = 1'b0;
    chk("t4_busy", busy, 1);
    chk("t4_no_swap_coincident", front_sel, 1);
    tick(); tick();
    chk("t4_still_waiting", front_sel, 1);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("t4_swapped", front_sel, 0);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (swap_ack) acks++;
    end
    chk("t4_exactly_one_ack", acks, 1);
    chk("t4_idle_after", busy, 0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    tick();
    chk("t4_frame_end_idle_ignored", front_sel, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
